// File: rtl/rx_link_ctrl_if.sv
// Host/decoder-facing signal bundle for rx_link_ctrl: link requests, decoder events and state/credit outputs.
interface rx_link_ctrl_if;
    localparam int unsigned CR_W = 6;
    localparam int unsigned ST_W = 3;

    logic            linkStart;
    logic            autoStart;
    logic            linkDisable;
    logic            gotNull;
    logic            gotFct;
    logic            gotNchar;
    logic            rxError;
    logic            fctSent;
    logic [CR_W-1:0] freeSlots;

    logic [ST_W-1:0] state;
    logic            rxEnable;
    logic            txEnable;
    logic            sendNulls;
    logic            sendFcts;
    logic            linkUp;
    logic            fctRequest;
    logic [CR_W-1:0] rxCredit;
    logic            creditError;

    modport master (
        output linkStart, autoStart, linkDisable, gotNull, gotFct, gotNchar, rxError, fctSent, freeSlots,
        input  state, rxEnable, txEnable, sendNulls, sendFcts, linkUp, fctRequest, rxCredit, creditError
    );

    modport slave (
        input  linkStart, autoStart, linkDisable, gotNull, gotFct, gotNchar, rxError, fctSent, freeSlots,
        output state, rxEnable, txEnable, sendNulls, sendFcts, linkUp, fctRequest, rxCredit, creditError
    );
endinterface

// File: rtl/rx_link_ctrl.sv
// Receive-side link state machine: ErrorReset..Run sequencing, start/timeout handling and FCT requests.
// Macro RX_CREDIT_EN enables receive-credit tracking and credit-violation detection.
module rx_link_ctrl #(
    parameter int unsigned T_6US4  = 64,
    parameter int unsigned T_12US8 = 128
) (
    input  logic          rxClk,
    input  logic          rxReset,
    rx_link_ctrl_if.slave link
);
    localparam int unsigned T_MAX    = (T_6US4 > T_12US8) ? T_6US4 : T_12US8;
    localparam int unsigned TMR_W    = $clog2(T_MAX + 1);
    localparam int unsigned CR_W     = 6;
    localparam int unsigned CRX_W    = CR_W + 1;
    localparam int unsigned FCT_STEP = 8;
    localparam int unsigned CR_MAX   = 56;

    typedef enum logic [2:0] {
        ST_ERR_RESET  = 3'd0,
        ST_ERR_WAIT   = 3'd1,
        ST_READY      = 3'd2,
        ST_STARTED    = 3'd3,
        ST_CONNECTING = 3'd4,
        ST_RUN        = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             null_seen_q, null_seen_d;
    logic [CR_W-1:0]  credit_q, credit_d;
    logic             credit_err_q, credit_err_c;
    logic             fct_req_q, fct_req_d;
    logic             rx_en_q, rx_en_d;
    logic             tx_en_q, tx_en_d;
    logic             send_nulls_q, send_nulls_d;
    logic             send_fcts_q, send_fcts_d;
    logic             link_up_q, link_up_d;

    logic             reset_done_c;
    logic             timeout_c;
    logic             link_err_c;
    logic             link_active_d;

    assign reset_done_c  = (timer_q == TMR_W'(T_6US4 - 1));
    assign timeout_c     = (timer_q == TMR_W'(T_12US8 - 1));
    assign link_err_c    = link.rxError || credit_err_c;
    assign link_active_d = (state_d == ST_CONNECTING) || (state_d == ST_RUN);

    // Next state and nullSeen; event priority: error > disable > FCT/N-char > NULL > timeout.
    always_comb begin
        state_d     = state_q;
        null_seen_d = null_seen_q;
        case (state_q)
            ST_ERR_RESET: begin
                null_seen_d = 1'b0;
                if (reset_done_c) state_d = ST_ERR_WAIT;
            end
            ST_ERR_WAIT: begin
                if (link.gotNull) null_seen_d = 1'b1;
                if (link.rxError || link.gotFct || link.gotNchar) state_d = ST_ERR_RESET;
                else if (timeout_c)                               state_d = ST_READY;
            end
            ST_READY: begin
                if (link.gotNull) null_seen_d = 1'b1;
                if (link.rxError || link.gotFct || link.gotNchar) begin
                    state_d = ST_ERR_RESET;
                end else if (!link.linkDisable &&
                             (link.linkStart || (link.autoStart && null_seen_q))) begin
                    state_d = ST_STARTED;
                end
            end
            ST_STARTED: begin
                if (link.gotNull) null_seen_d = 1'b1;
                if (link_err_c || link.linkDisable)     state_d = ST_ERR_RESET;
                else if (link.gotFct || link.gotNchar)  state_d = ST_ERR_RESET;
                else if (link.gotNull)                  state_d = ST_CONNECTING;
                else if (timeout_c)                     state_d = ST_ERR_RESET;
            end
            ST_CONNECTING: begin
                if (link_err_c || link.linkDisable) state_d = ST_ERR_RESET;
                else if (link.gotNchar)             state_d = ST_ERR_RESET;
                else if (link.gotFct)               state_d = ST_RUN;
                else if (timeout_c)                 state_d = ST_ERR_RESET;
            end
            ST_RUN: begin
                if (link_err_c || link.linkDisable) state_d = ST_ERR_RESET;
            end
            default: state_d = ST_ERR_RESET;
        endcase
    end

    // Dwell timer restarts on every state change and saturates while parked.
    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q)              timer_d = '0;
        else if (timer_q != {TMR_W{1'b1}})   timer_d = timer_q + TMR_W'(1);
    end

    // Link controls follow the state being entered so they line up with the state register.
    always_comb begin
        rx_en_d      = 1'b0;
        tx_en_d      = 1'b0;
        send_nulls_d = 1'b0;
        send_fcts_d  = 1'b0;
        link_up_d    = 1'b0;
        case (state_d)
            ST_ERR_WAIT, ST_READY: rx_en_d = 1'b1;
            ST_STARTED: begin
                rx_en_d      = 1'b1;
                tx_en_d      = 1'b1;
                send_nulls_d = 1'b1;
            end
            ST_CONNECTING: begin
                rx_en_d      = 1'b1;
                tx_en_d      = 1'b1;
                send_nulls_d = 1'b1;
                send_fcts_d  = 1'b1;
            end
            ST_RUN: begin
                rx_en_d      = 1'b1;
                tx_en_d      = 1'b1;
                send_nulls_d = 1'b1;
                send_fcts_d  = 1'b1;
                link_up_d    = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef RX_CREDIT_EN
    logic in_credit_c;

    assign in_credit_c  = (state_q == ST_CONNECTING) || (state_q == ST_RUN);
    // A violating event leaves the credit as it was and forces the link down.
    assign credit_err_c = in_credit_c &&
                          ((link.gotNchar && (credit_q == '0)) ||
                           (link.fctSent  && (credit_q > CR_W'(CR_MAX - FCT_STEP))));

    always_comb begin
        credit_d = credit_q;
        if (in_credit_c && !credit_err_c) begin
            if (link.fctSent)  credit_d = credit_d + CR_W'(FCT_STEP);
            if (link.gotNchar) credit_d = credit_d - CR_W'(1);
        end
        if (!credit_err_c && !link_active_d) credit_d = '0;
    end

    assign fct_req_d = link_active_d &&
                       (({1'b0, credit_d} + CRX_W'(FCT_STEP)) <= {1'b0, link.freeSlots});
`else
    logic fct_sent_unused;

    assign fct_sent_unused = link.fctSent;
    assign credit_err_c    = 1'b0;
    assign credit_d        = '0;
    assign fct_req_d       = link_active_d && (link.freeSlots >= CR_W'(FCT_STEP));
`endif

    // State, timer and registered outputs.
    always_ff @(posedge rxClk) begin
        if (rxReset) begin
            state_q      <= ST_ERR_RESET;
            timer_q      <= '0;
            null_seen_q  <= 1'b0;
            credit_q     <= '0;
            credit_err_q <= 1'b0;
            fct_req_q    <= 1'b0;
            rx_en_q      <= 1'b0;
            tx_en_q      <= 1'b0;
            send_nulls_q <= 1'b0;
            send_fcts_q  <= 1'b0;
            link_up_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            null_seen_q  <= null_seen_d;
            credit_q     <= credit_d;
            credit_err_q <= credit_err_c;
            fct_req_q    <= fct_req_d;
            rx_en_q      <= rx_en_d;
            tx_en_q      <= tx_en_d;
            send_nulls_q <= send_nulls_d;
            send_fcts_q  <= send_fcts_d;
            link_up_q    <= link_up_d;
        end
    end

    assign link.state       = 3'(state_q);
    assign link.rxEnable    = rx_en_q;
    assign link.txEnable    = tx_en_q;
    assign link.sendNulls   = send_nulls_q;
    assign link.sendFcts    = send_fcts_q;
    assign link.linkUp      = link_up_q;
    assign link.fctRequest  = fct_req_q;
    assign link.rxCredit    = credit_q;
    assign link.creditError = credit_err_q;
endmodule

// File: doc/rx_link_ctrl.md
RX_LINK_CTRL -- requirements
Module: rx_link_ctrl

Interface
REQ-001 Parameter T_6US4, default 64: ErrorReset dwell, in rxClk cycles.
REQ-002 Parameter T_12US8, default 128: ErrorWait dwell and Started/Connecting timeout, in rxClk cycles.
REQ-003 rxClk  in  1  sole clock; all state changes on its rising edge.
REQ-004 rxReset  in  1  synchronous, active-high reset.
REQ-005 linkStart  in  1  level; host requests link start.
REQ-006 autoStart  in  1  level; start on first received NULL.
REQ-007 linkDisable  in  1  level; forces link down.
REQ-008 gotNull  in  1  one-cycle pulse; NULL detected by char decoder.
REQ-009 gotFct  in  1  one-cycle pulse; FCT detected.
REQ-010 gotNchar  in  1  one-cycle pulse; data char or EOP/EEP received (nchar|lchar).
REQ-011 rxError  in  1  one-cycle pulse; parity or disconnect error.
REQ-012 fctSent  in  1  one-cycle pulse; transmitter sent one FCT.
REQ-013 freeSlots  in  6  free entries in receive queue, 0..56.
REQ-014 state  out  3  ErrorReset=0, ErrorWait=1, Ready=2, Started=3, Connecting=4, Run=5.
REQ-015 rxEnable, txEnable, sendNulls, sendFcts, linkUp  out  1 each  state-decoded controls.
REQ-016 fctRequest  out  1  level; transmitter may send one FCT.
REQ-017 rxCredit  out  6  outstanding receive credit, 0..56.
REQ-018 creditError  out  1  one-cycle pulse; credit violation.

Function
REQ-019 Outputs registered or decoded from registered state; no input-to-output combinational path except none.
REQ-020 Cycle timer SHALL clear on every state entry and count up each cycle while in state.
REQ-021 ErrorReset: all enables 0; after T_6US4 cycles -> ErrorWait.
REQ-022 ErrorWait: rxEnable=1; after T_12US8 cycles -> Ready; gotFct, gotNchar or rxError -> ErrorReset.
REQ-023 Ready: rxEnable=1; gotFct/gotNchar/rxError -> ErrorReset; else if !linkDisable & (linkStart | (autoStart & nullSeen)) -> Started.
REQ-024 Started: rxEnable=txEnable=sendNulls=1; gotNull -> Connecting; timer reaching T_12US8, gotFct, gotNchar or rxError -> ErrorReset.
REQ-025 Connecting: adds sendFcts=1; gotFct -> Run; timeout, gotNchar or rxError -> ErrorReset.
REQ-026 Run: rxEnable=txEnable=sendNulls=sendFcts=linkUp=1; rxError, creditError or linkDisable -> ErrorReset.
REQ-027 nullSeen flag set by gotNull in ErrorWait/Ready/Started, cleared in ErrorReset.
REQ-028 Priority on simultaneous events: rxError/creditError > linkDisable > gotFct/gotNchar > gotNull > timeout.
REQ-029 linkDisable in Started or Connecting -> ErrorReset.

Reset
REQ-030 rxReset SHALL force state=ErrorReset, timer=0, nullSeen=0, rxCredit=0, creditError=0, fctRequest=0, all enables 0, on the next edge, regardless of current state.
REQ-031 Deasserting rxReset begins ErrorReset dwell from timer=0.

Configuration
REQ-032 Macro RX_CREDIT_EN defined: rxCredit adds 8 on fctSent, subtracts 1 on gotNchar in Connecting/Run; both together net +7; cleared on ErrorReset entry.
REQ-033 With RX_CREDIT_EN: gotNchar at rxCredit=0, or fctSent with rxCredit>48, SHALL pulse creditError, leave rxCredit unchanged, and go to ErrorReset.
REQ-034 With RX_CREDIT_EN: fctRequest=1 iff state is Connecting/Run and rxCredit+8 <= freeSlots.
REQ-035 Without RX_CREDIT_EN: rxCredit=0, creditError=0, fctRequest=1 iff state is Connecting/Run and freeSlots>=8; fctSent ignored.

Verification
REQ-036 Reset, hold linkStart=0 -> state 0 for 64 cycles, 1 for 128 cycles, then 2 and stays.
REQ-037 Ready, linkStart=1, gotNull after 10 cycles, gotFct after 5 more -> states 3,4,5; linkUp=1.
REQ-038 Started, no gotNull for 128 cycles -> state 0; rxEnable=txEnable=0 next cycle.
REQ-039 ErrorWait, gotNchar pulse -> state 0; autoStart=1 with gotNull in Ready -> Started.
REQ-040 RX_CREDIT_EN, Run, freeSlots=8: fctRequest=1; fctSent -> rxCredit=8, fctRequest=0; 8 gotNchar -> 0; ninth gotNchar -> creditError pulse, state 0.
REQ-041 Run, rxReset asserted one cycle mid-operation -> all outputs at reset values next cycle.
